pc_unit: RTL and testbench

Parametrised program-counter / fetch-address generator for the pipelined CPU, sitting at the front of the F stage and driving the instruction-memory address. It generalises the plain sequential/branch PC with configurable width, reset and exception vectors, a stall-safe pending-redirect register, exception/ERET redirection, and fetch-address error detection. It has no memory handshake; the address is consumed combinationally by IM each cycle.

---
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator for the F stage.
// Handles sequential fetch, branch/jump redirects, exception and ERET redirects,
// and a pending-redirect register. A branch taken during a stall is held there
// until the stall releases, so that branch is not lost.
// adel flags fetch addresses that are misaligned or outside the instruction window.
module pc_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              m_stall,
    input  logic              change,
    input  logic [ADDR_W-1:0] npc,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_4add,
    output logic              adel,
    output logic              redirect_pending
);

    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LP_EXC_VEC  = ADDR_W'(EXC_VECTOR);
    // Window bounds carry one extra bit so base + size cannot overflow.
    localparam logic [ADDR_W:0]   LP_LO       = (ADDR_W + 1)'(IMEM_BASE);
    localparam logic [ADDR_W:0]   LP_HI       = LP_LO + (ADDR_W + 1)'(IMEM_BYTES);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_target;

    logic              w_hold;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_pend_valid_nxt;
    logic [ADDR_W-1:0] w_pend_target_nxt;
    logic [ADDR_W:0]   w_pc_ext;

    assign w_hold     = stall | m_stall;
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_pc_ext   = {1'b0, r_pc};

    // Next-state selection. Exception and ERET redirects ignore any stall.
    // A live branch target takes precedence over a pending one.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        if (exc_req) begin
            w_pc_nxt         = LP_EXC_VEC;
            w_pend_valid_nxt = 1'b0;
        end else if (eret_req) begin
            w_pc_nxt         = epc;
            w_pend_valid_nxt = 1'b0;
        end else if (w_hold) begin
            if (change) begin
                w_pend_target_nxt = npc;
                w_pend_valid_nxt  = 1'b1;
            end
        end else if (change) begin
            w_pc_nxt         = npc;
            w_pend_valid_nxt = 1'b0;
        end else if (r_pend_valid) begin
            w_pc_nxt         = r_pend_target;
            w_pend_valid_nxt = 1'b0;
        end else begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    // PC and pending-redirect registers. Reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= LP_RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    assign pc               = r_pc;
    assign pc_4add          = w_pc_plus4;
    assign redirect_pending = r_pend_valid;
    assign adel             = (r_pc[1:0] != 2'b00) | (w_pc_ext < LP_LO) | (w_pc_ext >= LP_HI);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
// It drives a vector table through the default 32-bit configuration, using a
// queue of expected results. Hand-written sequences cover asynchronous reset
// and 16-bit address wrap.
module tb_pc_unit;

    typedef struct {
        logic        stall;
        logic        m_stall;
        logic        change;
        logic [31:0] npc;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_adel;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        adel;
    } exp_t;

    localparam int NV = 25;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        m_stall;
    logic        change;
    logic [31:0] npc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_4add;
    logic        adel;
    logic        redirect_pending;

    logic        reset2;
    logic [15:0] pc16;
    logic [15:0] pc16_4add;
    logic        adel16;
    logic        pend16;

    int   n_checks;
    int   n_fail;
    vec_t vecs[NV];
    exp_t sb_q[$];
    exp_t e;

    pc_unit u_dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .m_stall          (m_stall),
        .change           (change),
        .npc              (npc),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc               (pc),
        .pc_4add          (pc_4add),
        .adel             (adel),
        .redirect_pending (redirect_pending)
    );

    pc_unit #(
        .ADDR_W     (16),
        .RESET_PC   (32'h0000_FFFC),
        .EXC_VECTOR (32'h0000_0180),
        .IMEM_BASE  (32'h0000_0000),
        .IMEM_BYTES (65536)
    ) u_dut16 (
        .clk              (clk),
        .reset            (reset2),
        .stall            (1'b0),
        .m_stall          (1'b0),
        .change           (1'b0),
        .npc              (16'h0000),
        .exc_req          (1'b0),
        .eret_req         (1'b0),
        .epc              (16'h0000),
        .pc               (pc16),
        .pc_4add          (pc16_4add),
        .adel             (adel16),
        .redirect_pending (pend16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic ms, input logic ch,
                                input logic [31:0] n, input logic ex, input logic er,
                                input logic [31:0] ep, input logic [31:0] xpc,
                                input logic xpend, input logic xadel);
        vec_t v;
        v.stall = s;  v.m_stall = ms; v.change = ch; v.npc = n;
        v.exc = ex;   v.eret = er;    v.epc = ep;
        v.exp_pc = xpc; v.exp_pend = xpend; v.exp_adel = xadel;
        return v;
    endfunction

    task automatic idle_inputs();
        stall = 0; m_stall = 0; change = 0; npc = 0;
        exc_req = 0; eret_req = 0; epc = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //             st ms ch npc           ex er epc           exp_pc        pend adel
        vecs[0]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0);
        vecs[2]  = mk(1, 0, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3008, 1, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 1, 0);
        vecs[4]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 1, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3100, 0, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3104, 0, 0);
        vecs[7]  = mk(1, 0, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3104, 1, 0);
        vecs[8]  = mk(1, 0, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3104, 1, 0);
        vecs[9]  = mk(0, 0, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3400, 0, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3404, 0, 0);
        vecs[11] = mk(1, 0, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3404, 1, 0);
        vecs[12] = mk(1, 0, 1, 32'h3600,     1, 1, 32'h3204,     32'h0000_4180, 0, 0);
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 1, 32'h3204,     32'h0000_3204, 0, 0);
        vecs[14] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3208, 0, 0);
        vecs[15] = mk(0, 0, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3002, 0, 1);
        vecs[16] = mk(0, 0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, 0, 1);
        vecs[17] = mk(0, 0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_6FFC, 0, 0);
        vecs[18] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 0, 1);
        vecs[19] = mk(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_2FFC, 0, 1);
        vecs[20] = mk(0, 1, 1, 32'h3010,     0, 0, 32'h0,        32'h0000_2FFC, 1, 1);
        vecs[21] = mk(0, 0, 0, 32'h0,        0, 1, 32'h3020,     32'h0000_3020, 0, 0);
        vecs[22] = mk(1, 0, 0, 32'h0,        0, 1, 32'h3040,     32'h0000_3040, 0, 0);
        vecs[23] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3044, 0, 0);
        vecs[24] = mk(1, 0, 1, 32'h3050,     0, 0, 32'h0,        32'h0000_3044, 1, 0);

        idle_inputs();
        reset  = 1'b0;
        reset2 = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",      pc, 32'h0000_3000);
        check("rst_pc_4add", pc_4add, 32'h0000_3004);
        check("rst_adel",    {31'b0, adel}, 32'h0);
        check("rst_pend",    {31'b0, redirect_pending}, 32'h0);
        reset = 1'b1;

        // Table-driven vectors, checked through the expected-result queue.
        for (int i = 0; i < NV; i++) begin
            stall    = vecs[i].stall;
            m_stall  = vecs[i].m_stall;
            change   = vecs[i].change;
            npc      = vecs[i].npc;
            exc_req  = vecs[i].exc;
            eret_req = vecs[i].eret;
            epc      = vecs[i].epc;
            sb_q.push_back('{pc: vecs[i].exp_pc, pend: vecs[i].exp_pend,
                             adel: vecs[i].exp_adel});
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue, required an entry (vec %0d)", i);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_pc", i),      pc, e.pc);
                check($sformatf("v%0d_pc_4add", i), pc_4add, e.pc + 32'd4);
                check($sformatf("v%0d_pend", i),    {31'b0, redirect_pending}, {31'b0, e.pend});
                check($sformatf("v%0d_adel", i),    {31'b0, adel}, {31'b0, e.adel});
            end
        end

        // Asynchronous reset mid-cycle, with a redirect pending.
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("arst_pc",   pc, 32'h0000_3000);
        check("arst_pend", {31'b0, redirect_pending}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_pc",   pc, 32'h0000_3004);
        check("post_rst_pend", {31'b0, redirect_pending}, 32'h0);

        // 16-bit instance: wrap past the top of the address space.
        check("w16_rst_pc",    {16'h0, pc16}, 32'h0000_FFFC);
        check("w16_rst_pc4",   {16'h0, pc16_4add}, 32'h0000_0000);
        check("w16_rst_adel",  {31'b0, adel16}, 32'h0);
        reset2 = 1'b1;
        @(posedge clk);
        #1;
        check("w16_pc_wrap",   {16'h0, pc16}, 32'h0000_0000);
        check("w16_pc4_wrap",  {16'h0, pc16_4add}, 32'h0000_0004);
        @(posedge clk);
        #1;
        check("w16_pc_next",   {16'h0, pc16}, 32'h0000_0004);
        #2;
        reset2 = 1'b0;
        #1;
        check("w16_arst_pc",   {16'h0, pc16}, 32'h0000_FFFC);
        check("w16_arst_pend", {31'b0, pend16}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
